// File: rtl/clock_pkg.sv
// Shared types and constants for the wall-clock set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_SET_HR  = 2'd2,
        ST_SET_MIN = 2'd3
    } state_t;

    localparam logic [3:0] SEP_CODE = 4'hE;
    localparam logic [6:0] MAX_HR   = 7'd23;
    localparam logic [6:0] MAX_MIN  = 7'd59;
    localparam logic [6:0] MAX_SEC  = 7'd59;

    // Two BCD digits {tens, ones} of an in-range (0..59) value.
    function automatic logic [7:0] to_bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchronizer -> debounce -> one-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press_pulse = level & ~level_d;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/pause/set controller owning hh:mm:ss, the 1 Hz prescaler and set-mode blink.
// Optional hourly chime output is built only when HOURLY_CHIME_EN is defined.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 25000000,
    parameter int INIT_HR         = 15
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_pause,
    output logic [31:0] out,
    output logic [7:0]  digit_blank,
    output logic [1:0]  mode,
    output logic        chime
);

    localparam int         PW        = $clog2(CLK_HZ + 1);
    localparam int         BW        = $clog2(BLINK_HALF + 1);
    localparam logic [7:0] BLANK_HR  = 8'hC0;
    localparam logic [7:0] BLANK_MIN = 8'h18;

    state_t        state, state_nx;
    logic          ev_mode, ev_inc, ev_pause;
    logic [6:0]    hr, min, sec;
    logic [PW-1:0] presc;
    logic          tick;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          blink_on, blink_on_nx;
    logic          in_set_nx;
    logic [7:0]    blank_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_50mhz(clk_50mhz), .rst(rst), .raw(btn_mode),  .press_pulse(ev_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk_50mhz(clk_50mhz), .rst(rst), .raw(btn_inc),   .press_pulse(ev_inc));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk_50mhz(clk_50mhz), .rst(rst), .raw(btn_pause), .press_pulse(ev_pause));

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nx;
    end

    // Mode is tested first everywhere, so a simultaneous pause is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:     if (ev_mode) state_nx = ST_SET_HR;
                        else if (ev_pause) state_nx = ST_PAUSE;
            ST_PAUSE:   if (ev_mode) state_nx = ST_SET_HR;
                        else if (ev_pause) state_nx = ST_RUN;
            ST_SET_HR:  if (ev_mode) state_nx = ST_SET_MIN;
            ST_SET_MIN: if (ev_mode) state_nx = ST_RUN;
            default:    state_nx = ST_RUN;
        endcase
    end

    assign tick = (state == ST_RUN) && (presc == PW'(CLK_HZ - 1));

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            hr    <= 7'(INIT_HR);
            min   <= '0;
            sec   <= '0;
            presc <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                if (sec == MAX_SEC) begin
                    sec <= '0;
                    if (min == MAX_MIN) begin
                        min <= '0;
                        hr  <= (hr == MAX_HR) ? 7'd0 : hr + 7'd1;
                    end else begin
                        min <= min + 7'd1;
                    end
                end else begin
                    sec <= sec + 7'd1;
                end
            end else if (state == ST_RUN) begin
                presc <= presc + PW'(1);
            end

            if (state == ST_SET_HR && ev_inc)
                hr <= (hr == MAX_HR) ? 7'd0 : hr + 7'd1;
            if (state == ST_SET_MIN && ev_inc)
                min <= (min == MAX_MIN) ? 7'd0 : min + 7'd1;
            // Leaving set mode restarts the second from a clean boundary.
            if (state == ST_SET_MIN && ev_mode) begin
                sec   <= '0;
                presc <= '0;
            end
        end
    end

    // Entry into a set state or an inc event restarts the blink in the on phase.
    assign in_set_nx = (state_nx == ST_SET_HR) || (state_nx == ST_SET_MIN);

    always_comb begin
        blink_cnt_nx = '0;
        blink_on_nx  = 1'b1;
        blank_nx     = '0;
        if (in_set_nx && state_nx == state && !ev_inc) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_on_nx = ~blink_on;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
                blink_on_nx  = blink_on;
            end
        end
        if (!blink_on_nx)
            blank_nx = (state_nx == ST_SET_HR) ? BLANK_HR : BLANK_MIN;
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            digit_blank <= '0;
        end else begin
            blink_cnt   <= blink_cnt_nx;
            blink_on    <= blink_on_nx;
            digit_blank <= blank_nx;
        end
    end

`ifdef HOURLY_CHIME_EN
    logic chime_q;

    // Set on the tick that lands on mm:ss == 00:00, cleared by the next tick.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst)
            chime_q <= 1'b0;
        else if (state == ST_RUN && state_nx != ST_RUN)
            chime_q <= 1'b0;
        else if (tick)
            chime_q <= (sec == MAX_SEC) && (min == MAX_MIN);
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign mode = state;
    assign out  = {to_bcd2(hr), SEP_CODE, to_bcd2(min), SEP_CODE, to_bcd2(sec)};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small clock/debounce/blink constants.
module tb_clock_set_ctrl;

    localparam int CLK_HZ  = 10;
    localparam int DEB     = 4;
    localparam int BH      = 3;
    localparam int INIT_HR = 15;

`ifdef HOURLY_CHIME_EN
    localparam logic CHIME_ON = 1'b1;
`else
    localparam logic CHIME_ON = 1'b0;
`endif

    localparam logic [2:0] B_MODE  = 3'b100;
    localparam logic [2:0] B_INC   = 3'b010;
    localparam logic [2:0] B_PAUSE = 3'b001;

    logic        clk_50mhz = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_mode  = 1'b0;
    logic        btn_inc   = 1'b0;
    logic        btn_pause = 1'b0;
    logic [31:0] out;
    logic [7:0]  digit_blank;
    logic [1:0]  mode;
    logic        chime;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0]  btns;
        logic [31:0] exp_out;
        logic [1:0]  exp_mode;
    } vec_t;

    vec_t tbl [6];

    always #5 clk_50mhz = ~clk_50mhz;

    clock_set_ctrl #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH), .INIT_HR(INIT_HR)
    ) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_pause(btn_pause), .out(out), .digit_blank(digit_blank), .mode(mode),
        .chime(chime)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] tod(input int h, input int m, input int s);
        return {bcd(h), 4'hE, bcd(m), 4'hE, bcd(s)};
    endfunction

    // Raw press; the debounced event lands on the 7th edge, then the raw line drops.
    task automatic press_start(input logic [2:0] b);
        {btn_mode, btn_inc, btn_pause} = b;
        tick(7);
        {btn_mode, btn_inc, btn_pause} = 3'b000;
    endtask

    task automatic press_full(input logic [2:0] b);
        press_start(b);
        tick(8);
    endtask

    initial begin
        tbl[0] = '{B_MODE, 32'h15E00E05, 2'd2};
        tbl[1] = '{B_INC,  32'h16E00E05, 2'd2};
        tbl[2] = '{B_INC,  32'h17E00E05, 2'd2};
        tbl[3] = '{B_MODE, 32'h17E00E05, 2'd3};
        tbl[4] = '{B_INC,  32'h17E01E05, 2'd3};
        tbl[5] = '{B_MODE, 32'h17E01E00, 2'd0};

        // Reset state and free-running seconds
        tick(2);
        chk("rst_out",   out, 32'h15E00E00);
        chk("rst_blank", 32'(digit_blank), 32'h0);
        chk("rst_mode",  32'(mode), 32'd0);
        chk("rst_chime", 32'(chime), 32'd0);
        rst = 1'b0;
        tick(25);
        chk("run25_out",  out, 32'h15E00E02);
        chk("run25_mode", 32'(mode), 32'd0);

        // 3-cycle glitch must be filtered
        btn_mode = 1'b1;
        tick(3);
        btn_mode = 1'b0;
        tick(7);
        chk("glitch_mode", 32'(mode), 32'd0);

        // Clean press held 20 cycles: one event at edge 7, then blink in SET_HR
        btn_mode = 1'b1;
        tick(6);
        chk("press_early", 32'(mode), 32'd0);
        tick(1);
        chk("press_event", 32'(mode), 32'd2);
        chk("blink_entry", 32'(digit_blank), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            chk("blink_hr", 32'(digit_blank), (((k / 3) % 2) != 0) ? 32'hC0 : 32'h0);
        end
        btn_mode = 1'b0;
        tick(10);
        chk("hold_mode",  32'(mode), 32'd2);
        chk("hold_time",  out, tod(15, 0, 4));
        chk("hold_blank", 32'(digit_blank), 32'hC0);

        // Hours up to 23, then wrap to 0 while inc forces the on phase
        for (int i = 1; i <= 8; i++) begin
            press_start(B_INC);
            chk("inc_hr", out, tod(15 + i, 0, 4));
            tick(8);
        end
        tick(1);
        chk("blink_off_a", 32'(digit_blank), 32'hC0);
        btn_inc = 1'b1;
        tick(1);
        chk("blink_off_b", 32'(digit_blank), 32'hC0);
        tick(1);
        chk("blink_off_c", 32'(digit_blank), 32'hC0);
        tick(1);
        chk("blink_on", 32'(digit_blank), 32'h0);
        tick(3);
        chk("blink_off_d", 32'(digit_blank), 32'hC0);
        tick(1);
        chk("inc_force_on", 32'(digit_blank), 32'h0);
        chk("hr_wrap", out, tod(0, 0, 4));
        btn_inc = 1'b0;
        tick(8);

        // Preload 23:59 and run through midnight
        for (int i = 1; i <= 23; i++) press_full(B_INC);
        chk("hr_23", out, tod(23, 0, 4));
        press_full(B_MODE);
        chk("set_min_mode", 32'(mode), 32'd3);
        for (int i = 1; i <= 59; i++) press_full(B_INC);
        chk("min_59", out, tod(23, 59, 4));
        tick(1);
        chk("blink_min", 32'(digit_blank), 32'h18);
        press_start(B_MODE);
        chk("exit_mode", 32'(mode), 32'd0);
        chk("exit_sec0", out, tod(23, 59, 0));
        chk("exit_blank", 32'(digit_blank), 32'h0);
        tick(580);
        chk("pre_wrap", out, tod(23, 59, 58));
        tick(19);
        chk("last_sec", out, tod(23, 59, 59));
        chk("chime_pre", 32'(chime), 32'd0);
        tick(1);
        chk("midnight", out, tod(0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            chk("chime_hi", 32'(chime), 32'(CHIME_ON));
            tick(1);
        end
        chk("chime_lo", 32'(chime), 32'd0);
        chk("after_wrap", out, tod(0, 0, 1));

        // Reset in the middle of a minute edit
        press_full(B_MODE);
        chk("to_set_hr", 32'(mode), 32'd2);
        press_full(B_MODE);
        chk("to_set_min", 32'(mode), 32'd3);
        press_start(B_INC);
        chk("edit_min", 32'(out[19:12]), 32'h01);
        tick(2);
        rst = 1'b1;
        #1;
        chk("rst_mid_mode",  32'(mode), 32'd0);
        chk("rst_mid_out",   out, 32'h15E00E00);
        chk("rst_mid_blank", 32'(digit_blank), 32'h0);
        chk("rst_mid_chime", 32'(chime), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(50);
        chk("run50", out, tod(15, 0, 5));

        // Full set sequence; time frozen during set states
        for (int i = 0; i < 6; i++) begin
            press_start(tbl[i].btns);
            chk("tbl_out",  out, tbl[i].exp_out);
            chk("tbl_mode", 32'(mode), 32'(tbl[i].exp_mode));
            tick(8);
        end
        tick(1);
        chk("presc_clr_a", out, tod(17, 1, 0));
        tick(1);
        chk("presc_clr_b", out, tod(17, 1, 1));

        // Pause holds time, inc ignored, mode beats pause
        press_start(B_PAUSE);
        chk("pause_mode", 32'(mode), 32'd1);
        chk("pause_out",  out, tod(17, 1, 1));
        tick(8);
        press_start(B_INC);
        chk("pause_inc_mode", 32'(mode), 32'd1);
        chk("pause_inc_out",  out, tod(17, 1, 1));
        tick(8);
        press_start(B_PAUSE);
        chk("resume_mode", 32'(mode), 32'd0);
        chk("resume_out",  out, tod(17, 1, 1));
        tick(8);
        press_start(B_MODE | B_PAUSE);
        chk("both_mode", 32'(mode), 32'd2);
        chk("both_out",  out, tod(17, 1, 3));
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller that sequences the wall-clock timekeeping datapath. It owns the hr/min/sec registers and the 1 Hz tick prescaler. It interprets three raw push-buttons (mode, increment, pause) through a run/pause/set state machine. It drives the packed 8-digit BCD display bus (hh E mm E ss) plus per-digit blank control for setting-mode blink, and sits between board buttons and the 7-segment scan driver.

Parameters:
CLK_HZ, 50000000, clock cycles per second; prescaler terminal count is CLK_HZ-1
DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (20 ms)
BLINK_HALF, 25000000, cycles per blink phase (on or off) in set modes
INIT_HR, 15, hour value loaded on reset (0..23)

Ports:
clk_50mhz  in  1  system clock
rst  in  1  asynchronous active-high reset
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
btn_pause  in  1  raw run/pause button, asynchronous, active-high
out  out  32  packed digits: [3:0] sec%10, [7:4] sec/10, [11:8] 4'hE, [15:12] min%10, [19:16] min/10, [23:20] 4'hE, [27:24] hr%10, [31:28] hr/10
digit_blank  out  8  bit i=1 means the scan driver blanks digit i
mode  out  2  current state encoding: 0 RUN, 1 PAUSE, 2 SET_HR, 3 SET_MIN
chime  out  1  hourly chime, present only with HOURLY_CHIME_EN; otherwise 0

Behaviour:
- Reset, async on rst high: state=RUN, hr=INIT_HR, min=0, sec=0, prescaler=0, blink counter=0, blink phase=on.
  - Resulting outputs: out = {hr/10, hr%10, E, 0, 0, E, 0, 0}, digit_blank=0, mode=0, chime=0.
  - Debouncer state clears; all buttons read as released.
  - A reset mid-edit discards the edit.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Rising edge of the accepted level gives a 1-cycle event pulse. Total press latency is 2 + DEBOUNCE_CYCLES + 1 cycles from the raw edge.
  - Holding a button gives exactly one event; there is no auto-repeat.
- FSM, driven only by event pulses:
  - RUN: pause→PAUSE; mode→SET_HR.
  - PAUSE: pause→RUN; mode→SET_HR.
  - SET_HR: inc→hr=(hr==23)?0:hr+1; mode→SET_MIN; pause ignored.
  - SET_MIN: inc→min=(min==59)?0:min+1; mode→RUN, and on that transition sec:=0 and prescaler:=0.
  - Mode and pause events in the same cycle: mode wins, pause is dropped.
  - Inc in RUN or PAUSE is ignored.
- Timekeeping:
  - The prescaler counts only in RUN. In all other states it holds its value.
  - At prescaler==CLK_HZ-1: prescaler:=0 and sec advances.
  - sec 59→0 carries to min; min 59→0 carries to hr; hr 23→0.
  - 23:59:59 → 00:00:00 happens in a single cycle.
  - Registers are 7-bit unsigned and never exceed 59/59/23.
- Display:
  - out is combinational from registers; digit conversion is /10 and %10 of in-range values.
  - Separators are always 4'hE.
- Blink:
  - In SET_HR/SET_MIN the blink counter runs and toggles phase every BLINK_HALF cycles.
  - Off phase: SET_HR blanks digits 7,6; SET_MIN blanks digits 4,3.
  - On entry to either set state the counter clears and the phase is on.
  - An inc event forces phase=on and clears the counter, so the edited field stays visible.
  - In RUN/PAUSE, digit_blank=0.
- Registered outputs (mode, digit_blank, chime) update on the clock edge after the causing event; out reflects register updates in the same cycle they occur.

Optional Feature:
HOURLY_CHIME_EN
- Defined: chime goes high on the RUN-state tick that produces min==0 && sec==0 (including the midnight wrap). It stays high for exactly CLK_HZ cycles, i.e. until the next tick.
  - Changes made in set modes never trigger the chime.
  - Entering PAUSE or a set state while high clears chime immediately.
- Undefined: chime is tied to 0 and the chime logic is absent.

Decomposition:
- Package clock_pkg holds:
  - state enum/localparams ST_RUN=0, ST_PAUSE=1, ST_SET_HR=2, ST_SET_MIN=3;
  - SEP_CODE=4'hE;
  - MAX_HR=23, MAX_MIN=59, MAX_SEC=59.
- One natural sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk_50mhz, rst, raw, press_pulse), instantiated three times.
- FSM, timekeeping, blink and display packing stay in clock_set_ctrl.

Test Plan:
Benches use CLK_HZ=10, DEBOUNCE_CYCLES=4, BLINK_HALF=3, INIT_HR=15.
- Reset then 25 clocks in RUN → sec=2, out[7:0]=8'h02, out[31:24]=8'h15, out[11:8]=out[23:20]=4'hE, mode=0.
- Preload 23:59:58 via set modes, run 20 clocks → 00:00:00; with HOURLY_CHIME_EN, chime high for exactly 10 cycles from the wrap tick.
- Raw btn_mode glitch of 3 cycles → no event, mode stays 0. Clean press held 20 cycles → exactly one event at 7 cycles after the edge, mode=2.
- In SET_HR with hr=23, press inc → hr=0; digit_blank alternates 8'h00/8'hC0 every 3 cycles, and the inc press forces 8'h00.
- Sequence mode, inc×2, mode, inc, mode from 15:00:05 → 17:01:00, state RUN, prescaler 0; time held constant during set states.
- Assert rst mid-SET_MIN → immediately mode=0, time=15:00:00, digit_blank=0; simultaneous mode+pause events from RUN → mode=2.
